branch_scan_sequencer: RTL

BRANCH_SCAN_SEQUENCER -- requirements
Module: branch_scan_sequencer

---
 rtl/branch_scan_sequencer_pkg.sv | 32 +++
 rtl/branch_scan_sequencer_if.sv | 36 +++
 rtl/branch_target_cache.sv | 50 +++++
 rtl/branch_scan_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/branch_scan_sequencer_pkg.sv
// Shared definitions for the branch scan sequencer: opcode encoding,
// FSM state type and bracket-classification helpers.
// No ports (package).
package branch_scan_sequencer_pkg;

  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] op_code_t;

  localparam op_code_t NOP = 4'h0;
  localparam op_code_t CBF = 4'h1;
  localparam op_code_t CBB = 4'h2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } scan_state_e;

  // Bracket that closes the scan: CBB going forward, CBF going backward.
  function automatic logic is_close(op_code_t op, logic dir);
    return dir ? (op == CBF) : (op == CBB);
  endfunction

  // Bracket that opens a nested level in the scan direction.
  function automatic logic is_open(op_code_t op, logic dir);
    return dir ? (op == CBB) : (op == CBF);
  endfunction

endpackage

// File: rtl/branch_scan_sequencer_if.sv
// Request / program-memory / status bundle of the branch scan sequencer.
//   master: requester + memory side (drives start/dir/start_pc/abort,
//           fetch_gnt/instr_valid/instr)
//   slave : the sequencer (drives fetch_req/fetch_addr, busy/done/error,
//           target_pc)
interface branch_scan_sequencer_if
  import branch_scan_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
);

  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] start_pc;
  logic              abort;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              instr_valid;
  op_code_t          instr;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] target_pc;
  logic              error;

  modport master (
    output start, dir, start_pc, abort, fetch_gnt, instr_valid, instr,
    input  fetch_req, fetch_addr, busy, done, target_pc, error
  );

  modport slave (
    input  start, dir, start_pc, abort, fetch_gnt, instr_valid, instr,
    output fetch_req, fetch_addr, busy, done, target_pc, error
  );

endinterface

// File: rtl/branch_target_cache.sv
// Single-entry cache of the last successful scan {dir, start_pc, target_pc}.
// Ports:
//   clock, reset_n            : clock, synchronous active-low reset
//   lookup_dir_i, lookup_pc_i : request being checked for a hit
//   fill_i, fill_*_i          : write the entry (on a done pulse)
//   clear_i                   : invalidate the entry (on an error pulse)
//   hit_c_o                   : combinational hit for the current lookup
//   target_o                  : stored target_pc
module branch_target_cache #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              lookup_dir_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  input  logic              fill_i,
  input  logic              fill_dir_i,
  input  logic [ADDR_W-1:0] fill_pc_i,
  input  logic [ADDR_W-1:0] fill_target_i,
  input  logic              clear_i,
  output logic              hit_c_o,
  output logic [ADDR_W-1:0] target_o
);

  logic              valid_q;
  logic              dir_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] target_q;

  // Entry storage; clear wins over fill (they never coincide in practice).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      dir_q    <= 1'b0;
      pc_q     <= '0;
      target_q <= '0;
    end else if (clear_i) begin
      valid_q  <= 1'b0;
    end else if (fill_i) begin
      valid_q  <= 1'b1;
      dir_q    <= fill_dir_i;
      pc_q     <= fill_pc_i;
      target_q <= fill_target_i;
    end
  end

  assign hit_c_o  = valid_q && (dir_q == lookup_dir_i) && (pc_q == lookup_pc_i);
  assign target_o = target_q;

endmodule

// File: rtl/branch_scan_sequencer.sv
// Scans program memory from a conditional branch to its matching bracket,
// tracking nesting depth, and reports the match address or an error.
// Optional feature: BRANCH_TARGET_CACHE_EN adds a single-entry target cache.
// Ports:
//   clock, reset_n : clock, synchronous active-low reset
//   bus (slave)    : start/dir/start_pc/abort request, fetch_req/fetch_addr/
//                    fetch_gnt memory request, instr_valid/instr response,
//                    busy/done/error status and target_pc result
module branch_scan_sequencer
  import branch_scan_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH_W = 8
) (
  input logic                    clock,
  input logic                    reset_n,
  branch_scan_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0]  ADDR_MAX  = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  scan_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  cursor_q, cursor_d;
  logic [ADDR_W-1:0]  target_q, target_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               dir_q, dir_d;
  logic               fetch_req_q, busy_q, done_q, error_q;

  logic start_at_edge_c;
  logic cursor_at_edge_c;
  logic close_c;
  logic open_c;

  // A start that would step past either end of memory fails immediately.
  assign start_at_edge_c  = bus.dir ? (bus.start_pc == '0) : (bus.start_pc == ADDR_MAX);
  assign cursor_at_edge_c = dir_q ? (cursor_q == '0) : (cursor_q == ADDR_MAX);
  assign close_c          = is_close(bus.instr, dir_q);
  assign open_c           = is_open(bus.instr, dir_q);

`ifdef BRANCH_TARGET_CACHE_EN
  logic [ADDR_W-1:0] start_pc_q, start_pc_d;
  logic              cache_hit_c;
  logic [ADDR_W-1:0] cache_target;

  // Filled in the DONE cycle, so the entry is ready for the next IDLE start.
  branch_target_cache #(
    .ADDR_W(ADDR_W)
  ) u_cache (
    .clock        (clock),
    .reset_n      (reset_n),
    .lookup_dir_i (bus.dir),
    .lookup_pc_i  (bus.start_pc),
    .fill_i       (state_q == DONE),
    .fill_dir_i   (dir_q),
    .fill_pc_i    (start_pc_q),
    .fill_target_i(target_q),
    .clear_i      (state_q == ERR),
    .hit_c_o      (cache_hit_c),
    .target_o     (cache_target)
  );

  // Request key kept for the cache fill.
  always_ff @(posedge clock) begin
    if (!reset_n) start_pc_q <= '0;
    else          start_pc_q <= start_pc_d;
  end
`endif

  // Next-state and datapath decisions.
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    target_d = target_q;
    depth_d  = depth_q;
    dir_d    = dir_q;
`ifdef BRANCH_TARGET_CACHE_EN
    start_pc_d = start_pc_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dir_d   = bus.dir;
          depth_d = '0;
`ifdef BRANCH_TARGET_CACHE_EN
          start_pc_d = bus.start_pc;
          if (cache_hit_c) begin
            state_d  = DONE;
            target_d = cache_target;
          end else
`endif
          if (start_at_edge_c) begin
            state_d = ERR;
          end else begin
            cursor_d = bus.dir ? (bus.start_pc - ADDR_W'(1)) : (bus.start_pc + ADDR_W'(1));
            state_d  = FETCH;
          end
        end
      end

      FETCH: begin
        if (bus.abort)          state_d = IDLE;
        else if (bus.fetch_gnt) state_d = WAIT;
      end

      WAIT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.instr_valid) begin
          if (close_c && (depth_q == '0)) begin
            state_d  = DONE;
            target_d = cursor_q;
          end else if (open_c && (depth_q == DEPTH_MAX)) begin
            state_d = ERR;
          end else begin
            if (close_c)     depth_d = depth_q - DEPTH_W'(1);
            else if (open_c) depth_d = depth_q + DEPTH_W'(1);
            // Non-match: step on, unless that would wrap the address.
            if (cursor_at_edge_c) begin
              state_d = ERR;
            end else begin
              cursor_d = dir_q ? (cursor_q - ADDR_W'(1)) : (cursor_q + ADDR_W'(1));
              state_d  = FETCH;
            end
          end
        end
      end

      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status outputs decoded from next state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cursor_q    <= '0;
      target_q    <= '0;
      depth_q     <= '0;
      dir_q       <= 1'b0;
      fetch_req_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      target_q    <= target_d;
      depth_q     <= depth_d;
      dir_q       <= dir_d;
      fetch_req_q <= (state_d == FETCH);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      error_q     <= (state_d == ERR);
    end
  end

  assign bus.fetch_req  = fetch_req_q;
  assign bus.fetch_addr = cursor_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.target_pc  = target_q;

endmodule
